// File: rtl/pht_updater_pkg.sv
// Shared widths and saturating-counter constants for the PHT update path.
package pht_updater_pkg;

    localparam int unsigned ScountAddrWidth  = 10;
    localparam int unsigned ScountStateWidth = 2;
    localparam int unsigned PhtWbusWidth     = 1 + ScountAddrWidth + ScountStateWidth;

    localparam logic [ScountStateWidth-1:0] SC_MAX = {ScountStateWidth{1'b1}};
    localparam logic [ScountStateWidth-1:0] SC_MIN = '0;

endpackage

// File: rtl/pht_upd_fifo.sv
// Pending-update FIFO: two pushes and one pop per cycle, with occupancy count.
module pht_upd_fifo #(
    parameter int unsigned DW    = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push0_i,
    input  logic [DW-1:0]              push0_data_i,
    input  logic                       push1_i,
    input  logic [DW-1:0]              push1_data_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              pop_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [DW-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            first_en, second_en, pop_ok;
    logic [DW-1:0]   first_data;

    // A lone slot-1 push lands in the first free entry, keeping the FIFO dense.
    always_comb begin
        first_en   = push0_i | push1_i;
        second_en  = push0_i & push1_i;
        first_data = push0_i ? push0_data_i : push1_data_i;
        pop_ok     = pop_i && (count_q != '0);
    end

    always_ff @(posedge clk_i) begin
        if (first_en) begin
            mem_q[wptr_q] <= first_data;
        end
        if (second_en) begin
            mem_q[wptr_q + PtrW'(1)] <= push1_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + PtrW'(first_en) + PtrW'(second_en);
            rptr_q  <= rptr_q + PtrW'(pop_ok);
            count_q <= count_q + CntW'(first_en) + CntW'(second_en) - CntW'(pop_ok);
        end
    end

    assign pop_data_o = mem_q[rptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/pht_updater.sv
// Queues resolved branches and retires one saturating-counter write to the PHT per cycle.
module pht_updater
    import pht_updater_pkg::*;
#(
    parameter int unsigned ADDR_W  = ScountAddrWidth,
    parameter int unsigned STATE_W = ScountStateWidth,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      res0_valid,
    input  logic [ADDR_W-1:0]         res0_addr,
    input  logic [STATE_W-1:0]        res0_state,
    input  logic                      res0_taken,
    input  logic                      res1_valid,
    input  logic [ADDR_W-1:0]         res1_addr,
    input  logic [STATE_W-1:0]        res1_state,
    input  logic                      res1_taken,
    output logic                      ready_o,
    output logic [ADDR_W+STATE_W:0]   pht_w_obus
);

    localparam int unsigned EntW = ADDR_W + STATE_W + 1;
    localparam int unsigned CntW = $clog2(DEPTH+1);
    localparam logic [STATE_W-1:0] StateMax = {STATE_W{1'b1}};
    localparam logic [STATE_W-1:0] StateMin = '0;

    logic [CntW-1:0]    count;
    logic [EntW-1:0]    pop_data;
    logic               pop;
    logic [ADDR_W-1:0]  e_addr;
    logic [STATE_W-1:0] e_state, base, new_state;
    logic               e_taken;

    logic               we_q, lw_valid_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [STATE_W-1:0] wdata_q;

    assign ready_o = (count <= CntW'(DEPTH - 2));
    assign pop     = (count != '0);

    pht_upd_fifo #(
        .DW    (EntW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (rst),
        .push0_i      (ready_o & res0_valid),
        .push0_data_i ({res0_addr, res0_state, res0_taken}),
        .push1_i      (ready_o & res1_valid),
        .push1_data_i ({res1_addr, res1_state, res1_taken}),
        .pop_i        (pop),
        .pop_data_o   (pop_data),
        .count_o      (count)
    );

    assign e_addr  = pop_data[EntW-1 -: ADDR_W];
    assign e_state = pop_data[STATE_W:1];
    assign e_taken = pop_data[0];

    // The carried state is stale if the previous write hit the same entry.
    always_comb begin
        base = e_state;
        if (lw_valid_q && (waddr_q == e_addr)) begin
            base = wdata_q;
        end
        if (e_taken) begin
            new_state = (base == StateMax) ? base : base + STATE_W'(1);
        end else begin
            new_state = (base == StateMin) ? base : base - STATE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            lw_valid_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= pop;
            if (pop) begin
                lw_valid_q <= 1'b1;
                waddr_q    <= e_addr;
                wdata_q    <= new_state;
            end
        end
    end

    assign pht_w_obus = {we_q, waddr_q, wdata_q};

endmodule

// File: tb/tb_pht_updater.sv
// Scoreboard bench for pht_updater: driver pushes expected writes, monitor pops on each we.
module tb_pht_updater;

    localparam int unsigned AW = 10;
    localparam int unsigned SW = 2;
    localparam int unsigned BW = AW + SW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          res0_valid, res0_taken, res1_valid, res1_taken;
    logic [AW-1:0] res0_addr, res1_addr;
    logic [SW-1:0] res0_state, res1_state;
    logic          ready_o;
    logic [BW-1:0] pht_w_obus;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    bit ignore   = 1'b0;
    logic [AW+SW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pht_updater #(
        .ADDR_W  (AW),
        .STATE_W (SW),
        .DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .res0_valid (res0_valid),
        .res0_addr  (res0_addr),
        .res0_state (res0_state),
        .res0_taken (res0_taken),
        .res1_valid (res1_valid),
        .res1_addr  (res1_addr),
        .res1_state (res1_state),
        .res1_taken (res1_taken),
        .ready_o    (ready_o),
        .pht_w_obus (pht_w_obus)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!ignore && pht_w_obus[BW-1] === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("write_unexpected", 32'(pht_w_obus), 32'h0);
            end else begin
                logic [AW+SW-1:0] e;
                e = exp_q.pop_front();
                check("write_data", 32'(pht_w_obus[BW-2:0]), 32'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        res0_valid = 1'b0;
        res1_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic issue(input logic v0, input logic [AW-1:0] a0, input logic [SW-1:0] s0,
                         input logic t0, input logic [SW-1:0] e0,
                         input logic v1, input logic [AW-1:0] a1, input logic [SW-1:0] s1,
                         input logic t1, input logic [SW-1:0] e1);
        int n = 0;
        res0_valid = 1'b0;
        res1_valid = 1'b0;
        while (ready_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(ready_o), 32'h1);
        res0_valid = v0; res0_addr = a0; res0_state = s0; res0_taken = t0;
        res1_valid = v1; res1_addr = a1; res1_state = s1; res1_taken = t1;
        if (v0) exp_q.push_back({a0, e0});
        if (v1) exp_q.push_back({a1, e1});
        step();
        res0_valid = 1'b0;
        res1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        idle(2);
        check("drain_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wr0;
        int acc;
        logic exp_ready [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        res0_valid = 1'b0; res0_addr = '0; res0_state = '0; res0_taken = 1'b0;
        res1_valid = 1'b0; res1_addr = '0; res1_state = '0; res1_taken = 1'b0;
        repeat (2) step();
        check("reset_bus", 32'(pht_w_obus), 32'h0);
        check("reset_ready", 32'(ready_o), 32'h1);
        rst = 1'b0;
        step();

        // Single update and its 2-cycle latency.
        issue(1'b1, 10'h005, 2'b01, 1'b1, 2'b10, 1'b0, '0, '0, 1'b0, '0);
        check("lat_n1_we", 32'(pht_w_obus[BW-1]), 32'h0);
        step();
        check("lat_n2_bus", 32'(pht_w_obus), 32'({1'b1, 10'h005, 2'b10}));
        step();
        check("lat_n3_we", 32'(pht_w_obus[BW-1]), 32'h0);
        drain();

        // Saturation at both ends.
        issue(1'b1, 10'h007, 2'b11, 1'b1, 2'b11, 1'b1, 10'h008, 2'b00, 1'b0, 2'b00);
        drain();

        // Same-address chaining, then record persistence across idle cycles.
        issue(1'b1, 10'h03A, 2'b01, 1'b1, 2'b10, 1'b1, 10'h03A, 2'b01, 1'b1, 2'b11);
        drain();
        idle(3);
        issue(1'b1, 10'h03A, 2'b00, 1'b1, 2'b11, 1'b0, '0, '0, 1'b0, '0);
        drain();

        // Slot 1 alone.
        wr0 = wr_cnt;
        issue(1'b0, '0, '0, 1'b0, '0, 1'b1, 10'h2C3, 2'b10, 1'b0, 2'b01);
        drain();
        check("res1_only_count", 32'(wr_cnt - wr0), 32'h1);

        // Backpressure: both slots held valid every cycle from empty.
        wr0 = wr_cnt;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            res0_valid = 1'b1; res0_addr = AW'(32'h100 + 2 * acc);
            res0_state = 2'b10; res0_taken = 1'b1;
            res1_valid = 1'b1; res1_addr = AW'(32'h101 + 2 * acc);
            res1_state = 2'b10; res1_taken = 1'b1;
            check("bp_ready", 32'(ready_o), 32'(exp_ready[k]));
            if (k >= 2) check("bp_one_write", 32'(pht_w_obus[BW-1]), 32'h1);
            if (ready_o === 1'b1) begin
                exp_q.push_back({res0_addr, 2'b11});
                exp_q.push_back({res1_addr, 2'b11});
                acc++;
            end
            step();
        end
        idle(0);
        drain();
        check("bp_write_count", 32'(wr_cnt - wr0), 32'(2 * acc));

        // Reset with three entries pending.
        res0_valid = 1'b1; res0_addr = 10'h010; res0_state = 2'b00; res0_taken = 1'b1;
        res1_valid = 1'b1; res1_addr = 10'h010; res1_state = 2'b00; res1_taken = 1'b1;
        step();
        step();
        res0_valid = 1'b0;
        res1_valid = 1'b0;
        rst = 1'b1;
        ignore = 1'b1;
        exp_q.delete();
        step();
        ignore = 1'b0;
        check("midrst_bus", 32'(pht_w_obus), 32'h0);
        check("midrst_ready", 32'(ready_o), 32'h1);
        step();
        rst = 1'b0;
        wr0 = wr_cnt;
        idle(4);
        check("midrst_no_write", 32'(wr_cnt - wr0), 32'h0);
        check("midrst_ready_idle", 32'(ready_o), 32'h1);
        issue(1'b1, 10'h010, 2'b00, 1'b1, 2'b01, 1'b0, '0, '0, 1'b0, '0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pht_updater.md
PHT_UPDATER -- requirements
Module: pht_updater

Interface
REQ-001 Parameter ADDR_W, default 10, is the PHT index width.
REQ-002 Parameter STATE_W, default 2, is the saturating-counter width.
REQ-003 Parameter DEPTH, default 4, is the pending-update FIFO depth; it is a power of two and at least 2.
REQ-004 Port: clk  in  1  single clock, rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: res0_valid  in  1  slot-0 branch resolved this cycle (older instruction).
REQ-007 Port: res0_addr  in  ADDR_W  PHT index used at predict time for slot 0.
REQ-008 Port: res0_state  in  STATE_W  counter value read at predict time for slot 0.
REQ-009 Port: res0_taken  in  1  actual direction for slot 0.
REQ-010 Port: res1_valid / res1_addr / res1_state / res1_taken  in  1/ADDR_W/STATE_W/1  same fields for slot 1 (younger instruction).
REQ-011 Port: ready_o  out  1  high when both slots can be accepted this cycle.
REQ-012 Port: pht_w_obus  out  1+ADDR_W+STATE_W  PHT write bus {we, waddr, wdata}, MSB first; connects directly to the PHT's w_ibus.

Function
REQ-013 ready_o SHALL be high when occupancy before this cycle's dequeue is at most DEPTH-2; it is combinational from the occupancy count.
REQ-014 Slots SHALL be ignored while ready_o is low; the upstream stage holds them.
REQ-015 When ready_o is high, valid slots SHALL be enqueued in the same cycle, slot 0 before slot 1; res1 alone enqueues one entry.
REQ-016 Each cycle with a non-empty FIFO, the module SHALL dequeue exactly one entry.
REQ-017 A dequeued entry SHALL produce a registered write: pht_w_obus.we = 1 in the following cycle.
REQ-018 Enqueue-to-write latency into an empty FIFO SHALL be 2 cycles: enqueue at cycle N, dequeue at N+1, we high during N+2.
REQ-019 pht_w_obus.we SHALL be 0 in any cycle with no write.
REQ-020 Base-state selection at dequeue:
- If a last-write record is valid and its address equals the entry address, base SHALL be the recorded data.
- Otherwise base SHALL be the entry's carried state.
REQ-021 New state SHALL be:
- taken: base+1, saturating at 2^STATE_W-1;
- not taken: base-1, saturating at 0;
- no wrap-around is permitted.
REQ-022 The last-write record {valid, addr, data} SHALL update on every issued write.
REQ-023 The last-write record SHALL persist until overwritten by a different address or cleared by reset.
REQ-024 Same-cycle enqueue of two entries and dequeue of one SHALL net occupancy +1.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 The FIFO SHALL never overflow or underflow.

Reset
REQ-027 While rst is high:
- FIFO occupancy, read pointer, write pointer and the last-write valid bit SHALL clear;
- pht_w_obus SHALL be all-zero in the next cycle;
- ready_o SHALL be high once occupancy is zero.
REQ-028 Reset asserted mid-operation SHALL discard all pending updates with no further write issued.

Structure
REQ-029 The shared defines package SHALL hold PhtWbusWidth, ScountAddrWidth and ScountStateWidth, plus the counter constants SC_MAX and SC_MIN; the module derives its bus widths from these.
REQ-030 One sub-module, pht_upd_fifo, SHALL hold the DEPTH-entry 2-write/1-read FIFO storage and occupancy.
REQ-031 Counter arithmetic and the write register SHALL reside in pht_updater.

Verification
REQ-032 Single update: res0 {addr=0x05, state=01, taken=1} at cycle N -> pht_w_obus={1,0x05,10} at N+2, we=0 at N+3.
REQ-033 Saturation:
- state=11, taken=1 -> wdata 11;
- state=00, taken=0 -> wdata 00.
REQ-034 Same-address chaining: both slots addr=0x3A, state=01, taken=1 in one cycle -> writes 10 then 11 on consecutive cycles.
REQ-035 Backpressure: hold both slots valid every cycle from empty (DEPTH=4):
- ready_o low once occupancy reaches 3;
- exactly one write per cycle;
- no entry lost or duplicated.
REQ-036 res1-only enqueue -> exactly one write with res1 fields.
REQ-037 Reset mid-run: rst with 3 entries pending -> no further we, ready_o=1, and the next update uses its carried state.
